// File: rtl/ufm_writer.sv
// Write-side UFM controller: shifts address/data into the altufm serial registers, then
// issues a program or sector-erase strobe and supervises the flash busy handshake.
module ufm_writer #(
  parameter int unsigned AW           = 9,
  parameter int unsigned DW           = 16,
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter int unsigned BUSY_TIMEOUT = 3_000_000
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          erase,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] data,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          ufm_arclk,
  output logic          ufm_arshft,
  output logic          ufm_ardin,
  output logic          ufm_drclk,
  output logic          ufm_drshft,
  output logic          ufm_drdin,
  output logic          ufm_program,
  output logic          ufm_erase,
  input  logic          ufm_busy
);

  localparam int unsigned CW = 22;
  localparam int unsigned NB = (AW > DW) ? AW : DW;
  localparam int unsigned BW = $clog2(NB);

  typedef enum logic [2:0] {
    S_IDLE, S_SH_ADDR, S_SH_DATA, S_STROBE, S_WAIT, S_FIN
  } state_t;

  state_t          r_state, w_state;
  logic [BW-1:0]   r_bit, w_bit;
  logic            r_ph, w_ph;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic            r_erase_op, w_erase_op;
  logic [AW-1:0]   r_asr, w_asr;
  logic [DW-1:0]   r_dsr, w_dsr;
  logic            r_busy, w_busy, r_done, w_done, r_error, w_error;
  logic            r_arclk, w_arclk, r_arshft, w_arshft, r_ardin, w_ardin;
  logic            r_drclk, w_drclk, r_drshft, w_drshft, r_drdin, w_drdin;
  logic            r_prog, w_prog, r_ers, w_ers;

  // Next state plus next value of every registered output.
  always_comb begin
    w_state    = r_state;
    w_bit      = r_bit;
    w_ph       = r_ph;
    w_cnt      = r_cnt;
    w_erase_op = r_erase_op;
    w_asr      = r_asr;
    w_dsr      = r_dsr;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    w_error    = r_error;
    w_arclk    = 1'b0;
    w_arshft   = 1'b0;
    w_ardin    = 1'b0;
    w_drclk    = 1'b0;
    w_drshft   = 1'b0;
    w_drdin    = 1'b0;
    w_prog     = 1'b0;
    w_ers      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_state    = S_SH_ADDR;
          w_busy     = 1'b1;
          w_erase_op = erase;
          w_asr      = address;
          w_dsr      = data;
          w_error    = 1'b0;
          w_bit      = '0;
          w_ph       = 1'b0;
          w_arshft   = 1'b1;
          w_ardin    = address[AW-1];
        end
      end
      S_SH_ADDR: begin
        w_arshft = 1'b1;
        if (!r_ph) begin
          w_ph    = 1'b1;
          w_arclk = 1'b1;
          w_ardin = r_asr[AW-1];
        end else if (r_bit == BW'(AW-1)) begin
          w_arshft = 1'b0;
          w_bit    = '0;
          w_ph     = 1'b0;
          if (r_erase_op) begin
            w_state = S_STROBE;
            w_cnt   = '0;
            w_ers   = 1'b1;
          end else begin
            w_state  = S_SH_DATA;
            w_drshft = 1'b1;
            w_drdin  = r_dsr[DW-1];
          end
        end else begin
          w_bit   = r_bit + BW'(1);
          w_ph    = 1'b0;
          w_asr   = {r_asr[AW-2:0], 1'b0};
          w_ardin = r_asr[AW-2];
        end
      end
      S_SH_DATA: begin
        w_drshft = 1'b1;
        if (!r_ph) begin
          w_ph    = 1'b1;
          w_drclk = 1'b1;
          w_drdin = r_dsr[DW-1];
        end else if (r_bit == BW'(DW-1)) begin
          w_drshft = 1'b0;
          w_bit    = '0;
          w_ph     = 1'b0;
          w_state  = S_STROBE;
          w_cnt    = '0;
          w_prog   = 1'b1;
        end else begin
          w_bit   = r_bit + BW'(1);
          w_ph    = 1'b0;
          w_dsr   = {r_dsr[DW-2:0], 1'b0};
          w_drdin = r_dsr[DW-2];
        end
      end
      S_STROBE: begin
        w_prog = !r_erase_op;
        w_ers  = r_erase_op;
        if (ufm_busy) begin
          w_prog  = 1'b0;
          w_ers   = 1'b0;
          w_state = S_WAIT;
          w_cnt   = '0;
        end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
          w_prog  = 1'b0;
          w_ers   = 1'b0;
          w_error = 1'b1;
          w_done  = 1'b1;
          w_state = S_FIN;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_WAIT: begin
        if (!ufm_busy) begin
          w_done  = 1'b1;
          w_state = S_FIN;
        end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          w_error = 1'b1;
          w_done  = 1'b1;
          w_state = S_FIN;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_FIN: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  // Reset abandons any flash operation in flight: strobes and done drop with no completion pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_bit      <= '0;
      r_ph       <= 1'b0;
      r_cnt      <= '0;
      r_erase_op <= 1'b0;
      r_asr      <= '0;
      r_dsr      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_arclk    <= 1'b0;
      r_arshft   <= 1'b0;
      r_ardin    <= 1'b0;
      r_drclk    <= 1'b0;
      r_drshft   <= 1'b0;
      r_drdin    <= 1'b0;
      r_prog     <= 1'b0;
      r_ers      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_bit      <= w_bit;
      r_ph       <= w_ph;
      r_cnt      <= w_cnt;
      r_erase_op <= w_erase_op;
      r_asr      <= w_asr;
      r_dsr      <= w_dsr;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_error    <= w_error;
      r_arclk    <= w_arclk;
      r_arshft   <= w_arshft;
      r_ardin    <= w_ardin;
      r_drclk    <= w_drclk;
      r_drshft   <= w_drshft;
      r_drdin    <= w_drdin;
      r_prog     <= w_prog;
      r_ers      <= w_ers;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign ufm_arclk   = r_arclk;
  assign ufm_arshft  = r_arshft;
  assign ufm_ardin   = r_ardin;
  assign ufm_drclk   = r_drclk;
  assign ufm_drshft  = r_drshft;
  assign ufm_drdin   = r_drdin;
  assign ufm_program = r_prog;
  assign ufm_erase   = r_ers;

endmodule

// File: tb/tb_ufm_writer.sv
// Directed bench for ufm_writer: table of program/erase commands with a simple flash responder,
// plus hand sequences for reset-in-flight and back-to-back starts.
module tb_ufm_writer;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          erase = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data = '0;
  logic          ufm_busy = 1'b0;
  logic          busy, done, error;
  logic          ufm_arclk, ufm_arshft, ufm_ardin, ufm_drclk, ufm_drshft, ufm_drdin;
  logic          ufm_program, ufm_erase;

  ufm_writer #(.AW(AW), .DW(DW), .ACK_TIMEOUT(16), .BUSY_TIMEOUT(1000)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .erase(erase),
    .address(address), .data(data), .busy(busy), .done(done), .error(error),
    .ufm_arclk(ufm_arclk), .ufm_arshft(ufm_arshft), .ufm_ardin(ufm_ardin),
    .ufm_drclk(ufm_drclk), .ufm_drshft(ufm_drshft), .ufm_drdin(ufm_drdin),
    .ufm_program(ufm_program), .ufm_erase(ufm_erase), .ufm_busy(ufm_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          er;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    int            ack;   // clocks from strobe seen to ufm_busy=1; -1 never acks
    int            blen;  // clocks ufm_busy stays 1; -1 stuck high
    int            lat;   // clocks from start to done
    logic          err;
    int            acl;
    int            dcl;
    int            pcy;
    int            ecy;
  } vec_t;

  vec_t vt[7];

  int nvec = 0, nmis = 0, n = 0;
  int arclk_cnt = 0, drclk_cnt = 0, prog_cyc = 0, ers_cyc = 0, done_cyc = 0, viol = 0;
  logic prev_arclk = 1'b0, prev_drclk = 1'b0;
  logic [AW-1:0] acap = '0;
  logic [DW-1:0] dcap = '0;
  int rsp_ack = -1, rsp_len = -1, rsp_seen = -1, rsp_bstart = -1;
  int a0, d0, p0, e0, dn0;

  function automatic logic [10:0] outs();
    return {busy, done, error, ufm_arclk, ufm_arshft, ufm_ardin,
            ufm_drclk, ufm_drshft, ufm_drdin, ufm_program, ufm_erase};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One falling edge: observe pins, then let the flash model react.
  task automatic tick();
    @(negedge clock);
    n++;
    if (ufm_arclk && !prev_arclk) begin
      arclk_cnt++;
      acap = {acap[AW-2:0], ufm_ardin};
    end
    if (ufm_drclk && !prev_drclk) begin
      drclk_cnt++;
      dcap = {dcap[DW-2:0], ufm_drdin};
    end
    prev_arclk = ufm_arclk;
    prev_drclk = ufm_drclk;
    if (ufm_program) prog_cyc++;
    if (ufm_erase) ers_cyc++;
    if (done) done_cyc++;
    if ((ufm_program && ufm_erase) ||
        ((ufm_program || ufm_erase) && (ufm_arshft || ufm_drshft)) ||
        (ufm_arclk && !ufm_arshft) || (ufm_drclk && !ufm_drshft))
      viol++;
    if (rsp_seen < 0 && (ufm_program || ufm_erase)) rsp_seen = n;
    if (rsp_ack >= 0 && rsp_seen >= 0 && rsp_bstart < 0 && n == rsp_seen + rsp_ack) begin
      ufm_busy   = 1'b1;
      rsp_bstart = n;
    end
    if (rsp_bstart >= 0 && rsp_len >= 0 && n == rsp_bstart + rsp_len) begin
      ufm_busy   = 1'b0;
      rsp_seen   = -1;
      rsp_bstart = -1;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit got;
    rsp_ack = v.ack; rsp_len = v.blen; rsp_seen = -1; rsp_bstart = -1;
    a0 = arclk_cnt; d0 = drclk_cnt; p0 = prog_cyc; e0 = ers_cyc; dn0 = done_cyc;
    n = 0;
    erase = v.er; address = v.addr; data = v.dat; start = 1'b1;
    tick();
    start = 1'b0;
    erase = ~v.er; address = ~v.addr; data = ~v.dat;
    chk($sformatf("v%0d_busy_on", idx), busy, 1);
    chk($sformatf("v%0d_err_clr", idx), error, 0);
    got = 1'b0;
    while (!got && n < 3000) begin
      tick();
      if (done) got = 1'b1;
    end
    if (!got) begin
      nvec++; nmis++;
      $display("FAIL v%0d_timeout: no done after %0d clocks", idx, n);
    end else begin
      chk($sformatf("v%0d_latency", idx), n, v.lat);
      chk($sformatf("v%0d_error", idx), error, v.err);
      chk($sformatf("v%0d_arclk", idx), arclk_cnt - a0, v.acl);
      chk($sformatf("v%0d_drclk", idx), drclk_cnt - d0, v.dcl);
      chk($sformatf("v%0d_addr_bits", idx), acap, v.addr);
      if (!v.er) chk($sformatf("v%0d_data_bits", idx), dcap, v.dat);
      chk($sformatf("v%0d_prog_cyc", idx), prog_cyc - p0, v.pcy);
      chk($sformatf("v%0d_erase_cyc", idx), ers_cyc - e0, v.ecy);
    end
    ufm_busy = 1'b0; rsp_ack = -1; rsp_seen = -1; rsp_bstart = -1;
    tick();
    chk($sformatf("v%0d_done_1clk", idx), done_cyc - dn0, 1);
    chk($sformatf("v%0d_busy_off", idx), busy, 0);
    chk($sformatf("v%0d_err_sticky", idx), error, v.err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //       er    addr     data       ack blen  lat   err  acl dcl pcy ecy
    vt[0] = '{1'b0, 9'h1A5, 16'hBEEF,  2, 100,  154, 1'b0, 9, 16,  3,  0};
    vt[1] = '{1'b1, 9'h100, 16'h1234,  1,  50,   71, 1'b0, 9,  0,  0,  2};
    vt[2] = '{1'b0, 9'h0FF, 16'h0001, -1,  -1,   67, 1'b1, 9, 16, 16,  0};
    vt[3] = '{1'b0, 9'h1FF, 16'hFFFF,  0,   3,   55, 1'b0, 9, 16,  1,  0};
    vt[4] = '{1'b0, 9'h000, 16'h0000,  0,  -1, 1052, 1'b1, 9, 16,  1,  0};
    vt[5] = '{1'b1, 9'h055, 16'hFFFF, -1,  -1,   35, 1'b1, 9,  0,  0, 16};
    vt[6] = '{1'b1, 9'h0AB, 16'h0000,  3,  -1, 1023, 1'b1, 9,  0,  0,  4};

    repeat (3) tick();
    chk("reset_outs", outs(), 0);
    reset_n = 1'b1;
    tick();
    chk("idle_outs", outs(), 0);

    // Reset while shifting data bit 7.
    rsp_ack = -1; d0 = drclk_cnt; dn0 = done_cyc; n = 0;
    erase = 1'b0; address = 9'h0AA; data = 16'h5A5A; start = 1'b1;
    tick();
    start = 1'b0;
    while (n < 33) tick();
    chk("t5_mid_data_drshft", ufm_drshft, 1);
    chk("t5_bits_before_reset", drclk_cnt - d0, 7);
    reset_n = 1'b0;
    tick();
    chk("t5_data_reset_outs", outs(), 0);
    reset_n = 1'b1;
    repeat (5) tick();
    chk("t5_data_no_done", done_cyc - dn0, 0);
    chk("t5_data_idle", busy, 0);

    // Reset while waiting on the flash busy flag.
    rsp_ack = 0; rsp_len = -1; rsp_seen = -1; rsp_bstart = -1; dn0 = done_cyc; n = 0;
    address = 9'h155; data = 16'h0F0F; start = 1'b1;
    tick();
    start = 1'b0;
    while (!(rsp_bstart >= 0 && n == rsp_bstart + 10) && n < 200) tick();
    chk("t5_in_wait", {busy, ufm_busy, ufm_program}, 3'b110);
    reset_n = 1'b0;
    tick();
    chk("t5_wait_reset_outs", outs(), 0);
    reset_n = 1'b1; ufm_busy = 1'b0; rsp_ack = -1; rsp_seen = -1; rsp_bstart = -1;
    repeat (5) tick();
    chk("t5_wait_no_done", done_cyc - dn0, 0);

    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);

    // Start held high across two commands; operands change while busy.
    rsp_ack = 0; rsp_len = 2; rsp_seen = -1; rsp_bstart = -1;
    e0 = ers_cyc; d0 = drclk_cnt; n = 0;
    erase = 1'b1; address = 9'h0C3; data = 16'h0000; start = 1'b1;
    tick();
    erase = 1'b0; address = 9'h13C; data = 16'hA55A;
    while (!done && n < 100) tick();
    chk("t6_done1_at", n, 22);
    chk("t6_cmd1_addr", acap, 9'h0C3);
    chk("t6_cmd1_no_data", drclk_cnt - d0, 0);
    chk("t6_cmd1_erase_cyc", ers_cyc - e0, 1);
    tick();
    chk("t6_idle_gap", {busy, done}, 2'b00);
    tick();
    chk("t6_busy2", busy, 1);
    start = 1'b0; p0 = prog_cyc; d0 = drclk_cnt;
    erase = 1'b1; address = 9'h000; data = 16'hFFFF;
    while (!done && n < 300) tick();
    chk("t6_done2_at", n, 77);
    chk("t6_cmd2_addr", acap, 9'h13C);
    chk("t6_cmd2_data", dcap, 16'hA55A);
    chk("t6_cmd2_drclk", drclk_cnt - d0, 16);
    chk("t6_cmd2_prog_cyc", prog_cyc - p0, 1);
    chk("t6_cmd2_error", error, 0);
    ufm_busy = 1'b0; rsp_ack = -1;
    repeat (3) tick();

    chk("pin_rule_violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
